// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared states, stall/flush vectors and helpers for pipe_ctrl
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        S_RUN        = 3'd0,
        S_MEM_WAIT   = 3'd1,
        S_EX_WAIT    = 3'd2,
        S_LU_BUBBLE  = 3'd3,
        S_IF_DISCARD = 3'd4
    } state_t;

    // Bit i of a vector addresses pipeline register i: 0=PC, 1=IF/ID, 2=ID/EX, 3=EX/MEM, 4=MEM/WB
    localparam logic [4:0] CTRL_NONE   = 5'b00000;
    localparam logic [4:0] STALL_MEM   = 5'b01111;
    localparam logic [4:0] FLUSH_MEM   = 5'b10000;
    localparam logic [4:0] STALL_EX    = 5'b00111;
    localparam logic [4:0] FLUSH_EX    = 5'b01000;
    localparam logic [4:0] STALL_LU    = 5'b00011;
    localparam logic [4:0] FLUSH_LU    = 5'b00100;
    localparam logic [4:0] STALL_IF    = 5'b00001;
    localparam logic [4:0] FLUSH_IF    = 5'b00010;
    localparam logic [4:0] FLUSH_REDIR = 5'b00110;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    // Increment that sticks at the top of the 8-bit range
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pipe_ctrl_redirect.sv
// rtl/pipe_ctrl_redirect.sv - pending redirect latch and registered redirect output
module pipe_ctrl_redirect #(
    parameter int PC_W = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frozen,
    input  logic            ex_redirect,
    input  logic [PC_W-1:0] ex_redirect_pc,
    output logic            accept,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc
);

    logic            pend_valid;
    logic [PC_W-1:0] pend_pc;
    logic [PC_W-1:0] target;

    // A live redirect is younger than a held one, so it wins the target
    assign accept = ~frozen & (ex_redirect | pend_valid);
    assign target = ex_redirect ? ex_redirect_pc : pend_pc;

    // Hold redirects that arrive while frozen; the newest overwrites any older one
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_pc    <= '0;
        end else if (accept) begin
            pend_valid <= 1'b0;
        end else if (frozen && ex_redirect) begin
            pend_valid <= 1'b1;
            pend_pc    <= ex_redirect_pc;
        end
    end

    // One-cycle redirect pulse to the PC stage, the cycle after acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= accept;
            if (accept) begin
                redirect_pc <= target;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush/redirect controller; PIPE_CTRL_PERF_EN adds perf counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int PC_W        = 64,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic            if_ready,
    input  logic            id_load_use,
    input  logic            ex_busy,
    input  logic            mem_req,
    input  logic            mem_ready,
    input  logic            ex_redirect,
    input  logic [PC_W-1:0] ex_redirect_pc,
    output logic [4:0]      stall_ctrl,
    output logic [4:0]      flush_ctrl,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            timeout_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [63:0]     perf_mem_stall,
    output logic [63:0]     perf_ex_stall,
    output logic [63:0]     perf_lu_bubble,
    output logic [63:0]     perf_redirect
`endif
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wait_cnt_q;
    logic [7:0] wait_cnt_inc;
    logic       mem_wait;
    logic       if_wait;
    logic       lu_req;
    logic       frozen;
    logic       accept;
    logic       lu_take;

    assign mem_wait     = mem_req & ~mem_ready;
    assign if_wait      = if_req & ~if_ready;
    // One bubble per load-use; an ID slot being flushed by a discard has no real operand
    assign lu_req       = id_load_use & (state_q != S_LU_BUBBLE) & (state_q != S_IF_DISCARD);
    assign frozen       = mem_wait | ex_busy;
    assign lu_take      = ~frozen & ~accept & lu_req;
    assign wait_cnt_inc = sat_inc8(wait_cnt_q);

    pipe_ctrl_redirect #(
        .PC_W(PC_W)
    ) u_redirect (
        .clk           (clk),
        .rst           (rst),
        .frozen        (frozen),
        .ex_redirect   (ex_redirect),
        .ex_redirect_pc(ex_redirect_pc),
        .accept        (accept),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and stall/flush vectors, highest-priority request first
    always_comb begin
        stall_ctrl = CTRL_NONE;
        flush_ctrl = CTRL_NONE;
        state_d    = S_RUN;
        if (mem_wait) begin
            stall_ctrl = STALL_MEM;
            flush_ctrl = FLUSH_MEM;
            state_d    = S_MEM_WAIT;
        end else if (ex_busy) begin
            stall_ctrl = STALL_EX;
            flush_ctrl = FLUSH_EX;
            state_d    = S_EX_WAIT;
        end else if (accept) begin
            stall_ctrl = if_wait ? STALL_IF : CTRL_NONE;
            flush_ctrl = FLUSH_REDIR | (if_wait ? FLUSH_IF : CTRL_NONE);
            state_d    = if_wait ? S_IF_DISCARD : S_RUN;
        end else if (lu_take) begin
            stall_ctrl = STALL_LU;
            flush_ctrl = FLUSH_LU;
            state_d    = S_LU_BUBBLE;
        end else if (if_wait) begin
            stall_ctrl = STALL_IF;
            flush_ctrl = FLUSH_IF;
        end
        // The stale fetch is still in flight: hold PC and drop whatever it returns
        if (state_q == S_IF_DISCARD) begin
            flush_ctrl    = flush_ctrl | FLUSH_IF;
            stall_ctrl[0] = if_ready ? stall_ctrl[0] : STOP;
            if (!frozen && !accept && !if_ready) begin
                state_d = S_IF_DISCARD;
            end
        end
    end

    // MEM-wait watchdog: saturating counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
            timeout_o  <= 1'b0;
        end else if (state_q == S_MEM_WAIT) begin
            wait_cnt_q <= (state_d == S_MEM_WAIT) ? wait_cnt_inc : 8'd0;
            if (wait_cnt_inc >= TIMEOUT_CNT) begin
                timeout_o <= 1'b1;
            end
        end else begin
            wait_cnt_q <= '0;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Event counters; they wrap naturally on overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_mem_stall <= '0;
            perf_ex_stall  <= '0;
            perf_lu_bubble <= '0;
            perf_redirect  <= '0;
        end else begin
            perf_mem_stall <= perf_mem_stall + {63'd0, mem_wait};
            perf_ex_stall  <= perf_ex_stall + {63'd0, ~mem_wait & ex_busy};
            perf_lu_bubble <= perf_lu_bubble + {63'd0, lu_take};
            perf_redirect  <= perf_redirect + {63'd0, accept};
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl against a behavioural model
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic        if_ready;
    logic        id_load_use;
    logic        ex_busy;
    logic        mem_req;
    logic        mem_ready;
    logic        ex_redirect;
    logic [63:0] ex_redirect_pc;
    logic [4:0]  stall_ctrl;
    logic [4:0]  flush_ctrl;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        timeout_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [63:0] perf_mem_stall, perf_ex_stall, perf_lu_bubble, perf_redirect;
`endif

    always #5 clk = ~clk;

    pipe_ctrl #(.PC_W(64), .MEM_TIMEOUT(255)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req        (if_req),
        .if_ready      (if_ready),
        .id_load_use   (id_load_use),
        .ex_busy       (ex_busy),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .ex_redirect   (ex_redirect),
        .ex_redirect_pc(ex_redirect_pc),
        .stall_ctrl    (stall_ctrl),
        .flush_ctrl    (flush_ctrl),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .timeout_o     (timeout_o)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_mem_stall(perf_mem_stall),
        .perf_ex_stall (perf_ex_stall),
        .perf_lu_bubble(perf_lu_bubble),
        .perf_redirect (perf_redirect)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: what the pipeline has been told so far
    bit          m_bubble_given;   // a load-use bubble was issued last cycle
    bit          m_discarding;     // a pre-redirect fetch is still to be dropped
    bit          m_was_mem_wait;   // previous cycle was a memory wait
    int          m_wait_cycles;    // consecutive cycles spent waiting after the first
    bit          m_timeout;
    bit          m_pend_v;
    logic [63:0] m_pend_pc;
    bit          m_rv;
    logic [63:0] m_rpc;

    logic [4:0]  e_stall, e_flush;
    bit          e_acc, e_lu, mw, iw, frz;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        mw    = mem_req && !mem_ready;
        iw    = if_req && !if_ready;
        frz   = mw || ex_busy;
        e_acc = !frz && (ex_redirect || m_pend_v);
        e_lu  = 1'b0;
        if (mw) begin
            e_stall = 5'b01111; e_flush = 5'b10000;
        end else if (ex_busy) begin
            e_stall = 5'b00111; e_flush = 5'b01000;
        end else if (e_acc) begin
            e_stall = iw ? 5'b00001 : 5'b00000;
            e_flush = iw ? 5'b00110 | 5'b00010 : 5'b00110;
        end else if (id_load_use && !m_bubble_given && !m_discarding) begin
            e_stall = 5'b00011; e_flush = 5'b00100; e_lu = 1'b1;
        end else if (iw) begin
            e_stall = 5'b00001; e_flush = 5'b00010;
        end else begin
            e_stall = 5'b00000; e_flush = 5'b00000;
        end
        if (m_discarding) begin
            e_flush = e_flush | 5'b00010;
            if (!if_ready) e_stall = e_stall | 5'b00001;
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_bubble_given = 0; m_discarding = 0; m_was_mem_wait = 0;
            m_wait_cycles = 0; m_timeout = 0; m_pend_v = 0; m_pend_pc = '0;
            m_rv = 0; m_rpc = '0;
        end else begin
            if (m_was_mem_wait) begin
                if (m_wait_cycles < 255) m_wait_cycles++;
                if (m_wait_cycles >= 255) m_timeout = 1;
                if (!mw) m_wait_cycles = 0;
            end else begin
                m_wait_cycles = 0;
            end
            m_was_mem_wait = mw;
            m_rv = e_acc;
            if (e_acc) m_rpc = ex_redirect ? ex_redirect_pc : m_pend_pc;
            if (e_acc) m_pend_v = 0;
            else if (frz && ex_redirect) begin
                m_pend_v = 1; m_pend_pc = ex_redirect_pc;
            end
            m_bubble_given = e_lu;
            m_discarding = !frz && (e_acc ? iw : (m_discarding && !if_ready));
        end
    endtask

    // Apply inputs, let them settle mid-cycle, compare everything against the model
    task automatic step(input bit r, input bit ir, input bit ird, input bit lu, input bit eb,
                        input bit mr, input bit mrd, input bit er, input logic [63:0] pc);
        rst = r; if_req = ir; if_ready = ird; id_load_use = lu; ex_busy = eb;
        mem_req = mr; mem_ready = mrd; ex_redirect = er; ex_redirect_pc = pc;
        #4;
        model_eval();
        if (!rst) begin
            check("stall_ctrl", {59'd0, stall_ctrl}, {59'd0, e_stall});
            check("flush_ctrl", {59'd0, flush_ctrl}, {59'd0, e_flush});
            check("redirect_valid", {63'd0, redirect_valid}, {63'd0, m_rv});
            check("redirect_pc", redirect_pc, m_rpc);
            check("timeout_o", {63'd0, timeout_o}, {63'd0, m_timeout});
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 64'd0);
    endtask

    initial begin
        // Reset
        step(1, 0, 0, 0, 0, 0, 0, 0, 64'd0); tick();
        step(1, 0, 0, 0, 0, 0, 0, 0, 64'd0); tick();
        idle();
        check("reset_stall", {59'd0, stall_ctrl}, 64'd0);
        check("reset_flush", {59'd0, flush_ctrl}, 64'd0);
        check("reset_rv", {63'd0, redirect_valid}, 64'd0);
        check("reset_timeout", {63'd0, timeout_o}, 64'd0);
        tick();

        // Load-use held two cycles gives exactly one bubble
        step(0, 0, 0, 1, 0, 0, 0, 0, 64'd0);
        check("lu_stall", {59'd0, stall_ctrl}, 64'b00011);
        check("lu_flush", {59'd0, flush_ctrl}, 64'b00100);
        tick();
        step(0, 0, 0, 1, 0, 0, 0, 0, 64'd0);
        check("lu_second_stall", {59'd0, stall_ctrl}, 64'd0);
        tick();
        idle(); tick();

        // MEM wait three cycles then release
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 1, 0, 0, 64'd0);
            check("mem_stall", {59'd0, stall_ctrl}, 64'b01111);
            check("mem_flush", {59'd0, flush_ctrl}, 64'b10000);
            tick();
        end
        step(0, 0, 0, 0, 0, 1, 1, 0, 64'd0);
        check("mem_release", {59'd0, stall_ctrl}, 64'd0);
        tick();
        idle(); tick();

        // Redirect during MEM wait is held until release (same-cycle release and accept)
        step(0, 0, 0, 0, 0, 1, 0, 0, 64'd0); tick();
        step(0, 0, 0, 0, 0, 1, 0, 1, 64'h80000100);
        check("frozen_no_redir_flush", {59'd0, flush_ctrl}, 64'b10000);
        tick();
        step(0, 0, 0, 0, 0, 1, 0, 0, 64'd0);
        check("frozen_no_rv", {63'd0, redirect_valid}, 64'd0);
        tick();
        step(0, 0, 0, 0, 0, 1, 1, 0, 64'd0);
        check("release_flush", {59'd0, flush_ctrl}, 64'b00110);
        tick();
        idle();
        check("held_rv", {63'd0, redirect_valid}, 64'd1);
        check("held_rpc", redirect_pc, 64'h80000100);
        tick();
        idle();
        check("held_rv_once", {63'd0, redirect_valid}, 64'd0);
        tick();

        // Two redirects during EX busy: youngest wins, single pulse
        step(0, 0, 0, 0, 1, 0, 0, 0, 64'd0); tick();
        step(0, 0, 0, 0, 1, 0, 0, 1, 64'h80000010); tick();
        step(0, 0, 0, 0, 1, 0, 0, 1, 64'h80000020); tick();
        step(0, 0, 0, 0, 0, 0, 0, 0, 64'd0);
        check("ex_release_flush", {59'd0, flush_ctrl}, 64'b00110);
        tick();
        idle();
        check("young_rv", {63'd0, redirect_valid}, 64'd1);
        check("young_rpc", redirect_pc, 64'h80000020);
        tick();
        idle();
        check("young_rv_once", {63'd0, redirect_valid}, 64'd0);
        tick();

        // Long MEM wait trips the sticky watchdog
        for (int i = 0; i < 256; i++) begin
            step(0, 0, 0, 0, 0, 1, 0, 0, 64'd0);
            if (i == 255) check("timeout_not_yet", {63'd0, timeout_o}, 64'd0);
            tick();
        end
        step(0, 0, 0, 0, 0, 1, 1, 0, 64'd0);
        check("timeout_set", {63'd0, timeout_o}, 64'd1);
        tick();
        for (int i = 0; i < 4; i++) begin idle(); tick(); end
        idle();
        check("timeout_sticky", {63'd0, timeout_o}, 64'd1);
        tick();
        step(1, 0, 0, 0, 0, 0, 0, 0, 64'd0); tick();
        idle();
        check("timeout_cleared", {63'd0, timeout_o}, 64'd0);
        tick();

        // Redirect with a fetch outstanding: discard the returning word
        step(0, 1, 0, 0, 0, 0, 0, 1, 64'h80000200);
        check("disc_accept_stall", {59'd0, stall_ctrl}, 64'b00001);
        check("disc_accept_flush", {59'd0, flush_ctrl}, 64'b00110);
        tick();
        step(0, 1, 0, 0, 0, 0, 0, 0, 64'd0);
        check("disc_rv", {63'd0, redirect_valid}, 64'd1);
        check("disc_stall", {59'd0, stall_ctrl}, 64'b00001);
        check("disc_flush", {59'd0, flush_ctrl}, 64'b00010);
        tick();
        step(0, 1, 0, 0, 0, 0, 0, 0, 64'd0); tick();
        step(0, 1, 1, 0, 0, 0, 0, 0, 64'd0);
        check("disc_drop_stall", {59'd0, stall_ctrl}, 64'd0);
        check("disc_drop_flush", {59'd0, flush_ctrl}, 64'b00010);
        tick();
        idle();
        check("disc_done", {59'd0, flush_ctrl}, 64'd0);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 1,
                 $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 15,
                 {$urandom, $urandom});
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
